lane_runner_ctrl: RTL and testbench

Parametrised successor to the accelerometer character mover. It converts the tilt reading from the accelerometer path into discrete lane changes with debounce and one-move-per-gesture semantics. It glides the sprite smoothly between lanes and adds a jump arc on a button input. It sits between the accelerometer SPI/scaling block and the VGA sprite renderer, and it advances only on a frame-rate `tick` enable.

---
 rtl/lane_runner_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lane_runner_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lane_runner_ctrl.sv
// Tilt-to-lane controller: debounced tilt classes drive one lane move per gesture,
// the sprite glides toward the lane x and a button launches a fixed jump arc.
module lane_runner_ctrl #(
  parameter int ACL_W      = 10,
  parameter int LEFT_MAX   = 212,
  parameter int RIGHT_MIN  = 416,
  parameter int RIGHT_MAX  = 469,
  parameter int NUM_LANES  = 3,
  parameter int START_LANE = 1,
  parameter int LANE_X0    = 140,
  parameter int LANE_PITCH = 120,
  parameter int Y          = 350,
  parameter int DEBOUNCE   = 4,
  parameter int STEP       = 8,
  parameter int JUMP_H     = 64,
  parameter int JUMP_STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_rst,
  input  logic             tick,
  input  logic [ACL_W-1:0] acl_in,
  input  logic             jump,
  output logic [9:0]       char_x,
  output logic [8:0]       char_y,
  output logic [3:0]       lane,
  output logic             moving,
  output logic             airborne
);

  localparam logic [1:0] CLS_NEUTRAL = 2'd0;
  localparam logic [1:0] CLS_LEFT    = 2'd1;
  localparam logic [1:0] CLS_RIGHT   = 2'd2;

  localparam logic G_ARMED   = 1'b0;
  localparam logic G_LATCHED = 1'b1;

  localparam logic [1:0] J_GROUND = 2'd0;
  localparam logic [1:0] J_RISE   = 2'd1;
  localparam logic [1:0] J_FALL   = 2'd2;

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);

  localparam logic [3:0]  LANE_LAST = 4'(NUM_LANES - 1);
  localparam logic [3:0]  LANE_INIT = 4'(START_LANE);
  localparam logic [10:0] X0        = 11'(LANE_X0);
  localparam logic [10:0] PITCH     = 11'(LANE_PITCH);
  localparam logic [10:0] STEP_X    = 11'(STEP);
  localparam logic [9:0]  X_INIT    = 10'(LANE_X0 + START_LANE * LANE_PITCH);
  localparam logic [8:0]  Y_GND     = 9'(Y);
  localparam logic [8:0]  Y_APEX    = 9'(Y - JUMP_H);
  localparam logic [8:0]  JSTEP     = 9'(JUMP_STEP);

  logic [1:0]    cls;
  logic [1:0]    deb_cls;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] cnt_next;
  logic          accepted;
  logic          gest;
  logic          gest_next;
  logic [3:0]    lane_next;
  logic [10:0]   target_x;
  logic [10:0]   cx_ext;
  logic [10:0]   d;
  logic [9:0]    x_next;
  logic [1:0]    jstate;
  logic [1:0]    j_next;
  logic [8:0]    y_next;
  logic          armed;
  logic          armed_next;

  always_comb begin
    cls = CLS_NEUTRAL;
    if (acl_in <= ACL_W'(LEFT_MAX))
      cls = CLS_LEFT;
    else if ((acl_in >= ACL_W'(RIGHT_MIN)) && (acl_in <= ACL_W'(RIGHT_MAX)))
      cls = CLS_RIGHT;
  end

  // Acceptance fires only on the tick the count arrives at DEBOUNCE, not while it sits saturated.
  always_comb begin
    if (cls == deb_cls)
      cnt_next = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + CW'(1);
    else
      cnt_next = CW'(1);
    accepted = (cnt_next == DEB_MAX) && ((cls != deb_cls) || (deb_cnt != DEB_MAX));
  end

  always_comb begin
    gest_next = gest;
    lane_next = lane;
    if (accepted) begin
      if (gest == G_ARMED) begin
        if (cls == CLS_LEFT) begin
          if (lane != 4'd0) lane_next = lane - 4'd1;
          gest_next = G_LATCHED;
        end else if (cls == CLS_RIGHT) begin
          if (lane < LANE_LAST) lane_next = lane + 4'd1;
          gest_next = G_LATCHED;
        end
      end else if (cls == CLS_NEUTRAL) begin
        gest_next = G_ARMED;
      end
    end
  end

  assign target_x = X0 + {7'd0, lane} * PITCH;
  assign cx_ext   = {1'b0, char_x};
  assign moving   = (cx_ext != target_x);

  always_comb begin
    d      = 11'd0;
    x_next = char_x;
    if (target_x > cx_ext) begin
      d      = target_x - cx_ext;
      x_next = 10'(cx_ext + ((d > STEP_X) ? STEP_X : d));
    end else if (target_x < cx_ext) begin
      d      = cx_ext - target_x;
      x_next = 10'(cx_ext - ((d > STEP_X) ? STEP_X : d));
    end
  end

  // The button must be seen low at some tick before it can launch another jump.
  always_comb begin
    j_next     = jstate;
    y_next     = char_y;
    armed_next = armed | ~jump;
    case (jstate)
      J_GROUND: begin
        if (jump && armed) begin
          armed_next = 1'b0;
          y_next     = char_y - JSTEP;
          j_next     = (y_next == Y_APEX) ? J_FALL : J_RISE;
        end
      end
      J_RISE: begin
        y_next = char_y - JSTEP;
        if (y_next == Y_APEX) j_next = J_FALL;
      end
      J_FALL: begin
        y_next = char_y + JSTEP;
        if (y_next == Y_GND) j_next = J_GROUND;
      end
      default: j_next = J_GROUND;
    endcase
  end

  assign airborne = (jstate != J_GROUND);

  always_ff @(posedge clk) begin
    if (rst || win_rst) begin
      lane    <= LANE_INIT;
      char_x  <= X_INIT;
      char_y  <= Y_GND;
      deb_cnt <= '0;
      deb_cls <= CLS_NEUTRAL;
      gest    <= G_ARMED;
      jstate  <= J_GROUND;
      armed   <= 1'b0;
    end else if (tick) begin
      lane    <= lane_next;
      char_x  <= x_next;
      char_y  <= y_next;
      deb_cnt <= cnt_next;
      deb_cls <= cls;
      gest    <= gest_next;
      jstate  <= j_next;
      armed   <= armed_next;
    end
  end

endmodule

// File: tb/tb_lane_runner_ctrl.sv
// Directed bench for lane_runner_ctrl: lane gestures, debounce, band edges, glide,
// jump arc, tick gating and mid-motion restart, with hand-derived expectations.
module tb_lane_runner_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       win_rst;
  logic       tick;
  logic [9:0] acl_in;
  logic       jump;
  logic [9:0] char_x;
  logic [8:0] char_y;
  logic [3:0] lane;
  logic       moving;
  logic       airborne;

  int vectors    = 0;
  int miscompares = 0;

  lane_runner_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .win_rst  (win_rst),
    .tick     (tick),
    .acl_in   (acl_in),
    .jump     (jump),
    .char_x   (char_x),
    .char_y   (char_y),
    .lane     (lane),
    .moving   (moving),
    .airborne (airborne)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int ex, input int ey, input int el,
                             input int em, input int ea);
    checkField({tag, ".char_x"},   {22'd0, char_x},   ex);
    checkField({tag, ".char_y"},   {23'd0, char_y},   ey);
    checkField({tag, ".lane"},     {28'd0, lane},     el);
    checkField({tag, ".moving"},   {31'd0, moving},   em);
    checkField({tag, ".airborne"}, {31'd0, airborne}, ea);
  endtask

  // One tick per two clocks, so every tick is followed by a tick-low cycle.
  task automatic applyStimulus(input int acl, input logic jmp, input int n);
    for (int i = 0; i < n; i++) begin
      acl_in = 10'(acl);
      jump   = jmp;
      tick   = 1'b1;
      @(posedge clk); #1;
      tick   = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; win_rst = 1'b0; tick = 1'b0; acl_in = 10'd300; jump = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset", 260, 350, 1, 0, 0);

    $display("[TB] right move");
    applyStimulus(450, 1'b0, 3);
    checkField("right.pre_accept_lane", {28'd0, lane}, 1);
    applyStimulus(450, 1'b0, 1);
    checkOutput("right.accept", 260, 350, 2, 1, 0);
    applyStimulus(450, 1'b0, 1);
    checkField("right.glide1", {22'd0, char_x}, 268);
    applyStimulus(450, 1'b0, 1);
    checkField("right.glide2", {22'd0, char_x}, 276);
    applyStimulus(450, 1'b0, 12);
    checkOutput("right.glide14", 372, 350, 2, 1, 0);
    applyStimulus(450, 1'b0, 1);
    checkOutput("right.arrived", 380, 350, 2, 0, 0);
    applyStimulus(450, 1'b0, 50);
    checkOutput("right.held", 380, 350, 2, 0, 0);

    $display("[TB] edge and rearm");
    applyStimulus(300, 1'b0, 4);
    applyStimulus(450, 1'b0, 4);
    checkOutput("edge.blocked", 380, 350, 2, 0, 0);
    applyStimulus(300, 1'b0, 4);
    applyStimulus(100, 1'b0, 4);
    checkOutput("edge.left", 380, 350, 1, 1, 0);
    applyStimulus(100, 1'b0, 15);
    checkOutput("edge.glide_back", 260, 350, 1, 0, 0);

    $display("[TB] debounce glitch and band edges");
    applyStimulus(300, 1'b0, 4);
    for (int r = 0; r < 5; r++) begin
      applyStimulus(100, 1'b0, 3);
      applyStimulus(300, 1'b0, 1);
    end
    checkOutput("glitch.no_move", 260, 350, 1, 0, 0);
    applyStimulus(500, 1'b0, 10);
    checkOutput("glitch.above_right", 260, 350, 1, 0, 0);
    applyStimulus(212, 1'b0, 4);
    checkField("band.left_max", {28'd0, lane}, 0);
    applyStimulus(300, 1'b0, 4);
    applyStimulus(416, 1'b0, 4);
    checkField("band.right_min", {28'd0, lane}, 1);
    applyStimulus(300, 1'b0, 4);
    applyStimulus(469, 1'b0, 4);
    checkField("band.right_max", {28'd0, lane}, 2);
    applyStimulus(300, 1'b0, 4);
    applyStimulus(470, 1'b0, 4);
    checkField("band.over_right_max", {28'd0, lane}, 2);
    applyStimulus(213, 1'b0, 4);
    checkField("band.over_left_max", {28'd0, lane}, 2);
    applyStimulus(300, 1'b0, 40);
    checkOutput("band.settled", 380, 350, 2, 0, 0);

    $display("[TB] jump");
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(300, 1'b1, 1);
      if (i <= 8) begin
        checkField($sformatf("jump.y%0d", i), {23'd0, char_y}, 350 - 8 * i);
        checkField($sformatf("jump.air%0d", i), {31'd0, airborne}, 1);
      end else if (i <= 16) begin
        checkField($sformatf("jump.y%0d", i), {23'd0, char_y}, 286 + 8 * (i - 8));
        checkField($sformatf("jump.air%0d", i), {31'd0, airborne}, (i < 16) ? 1 : 0);
      end else begin
        checkField($sformatf("jump.hold_y%0d", i), {23'd0, char_y}, 350);
        checkField($sformatf("jump.hold_air%0d", i), {31'd0, airborne}, 0);
      end
    end
    applyStimulus(300, 1'b0, 1);
    applyStimulus(300, 1'b1, 1);
    checkOutput("jump.second", 380, 342, 2, 0, 1);
    applyStimulus(300, 1'b1, 15);
    checkOutput("jump.second_land", 380, 350, 2, 0, 0);

    $display("[TB] mid-operation restart");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(100, 1'b0, 4);
    applyStimulus(100, 1'b0, 15);
    checkOutput("restart.at_lane0", 140, 350, 0, 0, 0);
    applyStimulus(300, 1'b0, 4);
    applyStimulus(450, 1'b1, 4);
    checkOutput("restart.launch", 140, 318, 1, 1, 1);
    applyStimulus(450, 1'b1, 3);
    checkOutput("restart.midflight", 164, 294, 1, 1, 1);
    tick = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("restart.tick_low_hold", 164, 294, 1, 1, 1);
    win_rst = 1'b1;
    @(posedge clk); #1;
    win_rst = 1'b0;
    checkOutput("restart.after_win_rst", 260, 350, 1, 0, 0);
    applyStimulus(450, 1'b1, 4);
    checkOutput("restart.rearmed", 260, 350, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
